// File: rtl/spi_slave_shift_engine_if.sv
`timescale 1ns/1ps
// SPI pin and word-handshake bundle for spi_slave_shift_engine.
// dbgState mirrors the engine FSM (0 WAIT_RELEASE, 1 IDLE, 2 ACTIVE).
interface spi_slave_shift_engine_if #(
    parameter int WIDTH = 8
);
    logic             SCK;
    logic             _CS;
    logic             MOSI;
    logic             MISO;
    logic             miso_oe;
    logic [WIDTH-1:0] tx_data;
    logic             tx_load;
    logic             tx_ready;
    logic             tx_underrun;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             frame_abort;
    logic [1:0]       dbgState;

    // tx_load is honoured only in a cycle where tx_ready=1; rx_valid, tx_underrun
    // and frame_abort are single-cycle strobes with no back-pressure.
    modport slave (
        input  SCK, _CS, MOSI, tx_data, tx_load,
        output MISO, miso_oe, tx_ready, tx_underrun, rx_data, rx_valid, frame_abort, dbgState
    );

    modport master (
        output SCK, _CS, MOSI, tx_data, tx_load,
        input  MISO, miso_oe, tx_ready, tx_underrun, rx_data, rx_valid, frame_abort, dbgState
    );
endinterface

// File: rtl/spi_slave_shift_engine.sv
`timescale 1ns/1ps
// Full-duplex SPI slave shift engine running on CLK with oversampled SCK/_CS/MOSI,
// a one-word TX holding buffer, RX word strobe and underrun/abort flags.
module spi_slave_shift_engine #(
    parameter int WIDTH       = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    CLK,
    input  logic                    _RST,
    spi_slave_shift_engine_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        WAIT_RELEASE = 2'd0,
        IDLE         = 2'd1,
        ACTIVE       = 2'd2
    } state_t;

    state_t state, stateNext;

    logic [SYNC_STAGES-1:0] sckSync, csSync, mosiSync;
    logic                   sckDly;
    logic                   sckS, csS, mosiS;
    logic                   sckEdge, leadEdge, trailEdge, sampleEdge, driveEdge;
    logic                   frameStart, frameEnd, inFrame;
    logic                   doSample, doDrive, wordDone, wordStart;

    logic [CW-1:0]    bitCnt;
    logic [WIDTH-1:0] txBuf, txShift, rxShift, rxData, rxNext, wordSrc;
    logic             txFull, misoReg, rxValid, txUnderrun, frameAbort;

    function automatic logic headBit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shiftWord(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            sckSync  <= '0;
            csSync   <= '0;
            mosiSync <= '0;
            sckDly   <= 1'b0;
        end else begin
            sckSync  <= {sckSync[SYNC_STAGES-2:0], bus.SCK};
            csSync   <= {csSync[SYNC_STAGES-2:0], bus._CS};
            mosiSync <= {mosiSync[SYNC_STAGES-2:0], bus.MOSI};
            sckDly   <= sckS;
        end
    end

    assign sckS       = sckSync[SYNC_STAGES-1];
    assign csS        = csSync[SYNC_STAGES-1];
    assign mosiS      = mosiSync[SYNC_STAGES-1];
    assign sckEdge    = sckS != sckDly;
    assign leadEdge   = sckEdge && (sckS != CPOL);
    assign trailEdge  = sckEdge && (sckS == CPOL);
    assign sampleEdge = CPHA ? trailEdge : leadEdge;
    assign driveEdge  = CPHA ? leadEdge : trailEdge;

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) state <= WAIT_RELEASE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        frameStart = 1'b0;
        frameEnd   = 1'b0;
        case (state)
            WAIT_RELEASE: if (csS) stateNext = IDLE;
            IDLE: begin
                if (!csS) begin
                    stateNext  = ACTIVE;
                    frameStart = 1'b1;
                end
            end
            ACTIVE: begin
                if (csS) begin
                    stateNext = IDLE;
                    frameEnd  = 1'b1;
                end
            end
            default: stateNext = WAIT_RELEASE;
        endcase
    end

    // _CS release wins over any SCK edge seen in the same cycle.
    assign inFrame  = (state == ACTIVE) && !frameEnd;
    assign doSample = inFrame && sampleEdge;
    assign doDrive  = inFrame && driveEdge;
    assign wordDone = doSample && (bitCnt == LAST_BIT);
    // CPHA=0 starts the next word on the drive edge right after the last sample;
    // CPHA=1 starts it at once so the first bit is ready for the next drive edge.
    assign wordStart = frameStart ||
                       (CPHA ? wordDone : (doDrive && (bitCnt == '0)));
    assign wordSrc   = txFull ? txBuf : '0;
    assign rxNext    = MSB_FIRST ? {rxShift[WIDTH-2:0], mosiS} : {mosiS, rxShift[WIDTH-1:1]};

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            bitCnt     <= '0;
            txBuf      <= '0;
            txFull     <= 1'b0;
            txShift    <= '0;
            rxShift    <= '0;
            rxData     <= '0;
            misoReg    <= 1'b0;
            rxValid    <= 1'b0;
            txUnderrun <= 1'b0;
            frameAbort <= 1'b0;
        end else begin
            rxValid    <= 1'b0;
            txUnderrun <= 1'b0;
            frameAbort <= 1'b0;
            if (frameEnd) begin
                frameAbort <= (bitCnt != '0);
                bitCnt     <= '0;
                rxShift    <= '0;
                misoReg    <= 1'b0;
            end else begin
                if (frameStart) bitCnt <= '0;
                if (doSample) begin
                    rxShift <= rxNext;
                    if (bitCnt == LAST_BIT) begin
                        rxData  <= rxNext;
                        rxValid <= 1'b1;
                        bitCnt  <= '0;
                    end else begin
                        bitCnt <= bitCnt + CW'(1);
                    end
                end
                if (wordStart) begin
                    txUnderrun <= !txFull;
                    if (CPHA) begin
                        txShift <= wordSrc;
                    end else begin
                        misoReg <= headBit(wordSrc);
                        txShift <= shiftWord(wordSrc);
                    end
                end else if (doDrive) begin
                    misoReg <= headBit(txShift);
                    txShift <= shiftWord(txShift);
                end
            end
            // The consume sees the old buffer state; a load in the same cycle refills it.
            if (wordStart) txFull <= 1'b0;
            if (bus.tx_load && !txFull) begin
                txBuf  <= bus.tx_data;
                txFull <= 1'b1;
            end
        end
    end

    assign bus.MISO        = misoReg;
    assign bus.miso_oe     = (state == ACTIVE);
    assign bus.tx_ready    = !txFull;
    assign bus.tx_underrun = txUnderrun;
    assign bus.rx_data     = rxData;
    assign bus.rx_valid    = rxValid;
    assign bus.frame_abort = frameAbort;
    assign bus.dbgState    = state;
endmodule
